// File: rtl/bel_fft_loader_pkg.sv
// Shared definitions for the FFT sample loader: FSM encodings, bus widths,
// and the capture counter width helper.
package bel_fft_loader_pkg;

  localparam int unsigned AV_ADDR_W = 32;
  localparam int unsigned AV_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    FLUSH
  } ctrl_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_RE,
    W_IM
  } wr_state_e;

  // Counters must be able to hold the value n itself, hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/bel_fft_sample_fifo.sv
// Synchronous sample FIFO. A pop on a full FIFO frees the slot for a
// simultaneous push, so a full FIFO being drained never drops data.
module bel_fft_sample_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [width-1:0] data_i,
  output logic [width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == DEPTH_CNT);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pop is resolved first so it can make room.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, no reset needed since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bel_fft_sample_loader.sv
// Captures fft_size audio samples into an FFT input buffer in memory as
// complex words (imaginary part zero) through an Avalon-MM write master.
module bel_fft_sample_loader
  import bel_fft_loader_pkg::*;
#(
  parameter int unsigned word_width = 16,
  parameter int unsigned fft_size   = 256,
  parameter int unsigned fifo_depth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [word_width-1:0] st_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [AV_ADDR_W-1:0]  base_adr_i,
  input  logic                  start_i,
  output logic [AV_ADDR_W-1:0]  m_address,
  output logic [AV_DATA_W-1:0]  m_writedata,
  output logic                  m_write,
  input  logic                  m_waitrequest,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam int unsigned CW      = cnt_width(fft_size);
  localparam logic [CW-1:0] FFT_CNT = CW'(fft_size);
  // Byte stride per sample: one 32-bit word, or a real/imaginary word pair.
  localparam int unsigned SHIFT   = (word_width == 32) ? 3 : 2;

  if (!(word_width == 16 || word_width == 32)) begin : g_bad_width
    $error("bel_fft_sample_loader: word_width must be 16 or 32");
  end
  if (fft_size < 4 || fft_size > 4096 || (fft_size & (fft_size - 1)) != 0) begin : g_bad_fft
    $error("bel_fft_sample_loader: fft_size must be a power of two in 4..4096");
  end
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("bel_fft_sample_loader: fifo_depth must be a power of two >= 2");
  end

  ctrl_state_e          ctrl_q, ctrl_d;
  wr_state_e            wr_q, wr_d;
  logic [AV_ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]        acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [AV_ADDR_W-1:0] m_address_q, m_address_d;
  logic [AV_DATA_W-1:0] m_writedata_q, m_writedata_d;
  logic                 m_write_q, m_write_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [word_width-1:0] fifo_dout;
  logic                  wr_accept, word_done, load;

  assign st_ready    = 1'b1;
  assign m_address   = m_address_q;
  assign m_writedata = m_writedata_q;
  assign m_write     = m_write_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign overflow_o  = ovf_q;
  assign wr_accept   = m_write_q && !m_waitrequest;

  bel_fft_sample_fifo #(
    .width(word_width),
    .depth(fifo_depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .data_i (st_data),
    .data_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Writer: drains the FIFO onto the bus, one or two words per sample.
  // wr_cnt_d is settled before the reload so a back-to-back pop addresses
  // the next sample slot with the same shift as a pop from W_IDLE.
  always_comb begin
    wr_d          = wr_q;
    wr_cnt_d      = wr_cnt_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    m_write_d     = m_write_q;
    fifo_pop      = 1'b0;
    word_done     = 1'b0;
    load          = 1'b0;
    unique case (wr_q)
      W_IDLE: load = !fifo_empty;
      W_RE: begin
        if (wr_accept) begin
          if (word_width == 32) begin
            wr_d          = W_IM;
            m_address_d   = base_q + ((AV_ADDR_W'(wr_cnt_q) << 3) | AV_ADDR_W'(4));
            m_writedata_d = '0;
          end else begin
            word_done = 1'b1;
          end
        end
      end
      W_IM: word_done = wr_accept;
      default: wr_d = W_IDLE;
    endcase
    if (word_done) begin
      wr_cnt_d  = wr_cnt_q + CW'(1);
      load      = !fifo_empty;
      m_write_d = 1'b0;
      wr_d      = W_IDLE;
    end
    if (load) begin
      fifo_pop      = 1'b1;
      wr_d          = W_RE;
      m_write_d     = 1'b1;
      m_address_d   = base_q + (AV_ADDR_W'(wr_cnt_d) << SHIFT);
      m_writedata_d = AV_DATA_W'(fifo_dout);
    end
    if (ctrl_q == IDLE && start_i) wr_cnt_d = '0;
  end

  // Control: arming, sample admission with overflow tracking, completion.
  always_comb begin
    ctrl_d    = ctrl_q;
    base_d    = base_q;
    acc_cnt_d = acc_cnt_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fifo_push = 1'b0;
    unique case (ctrl_q)
      IDLE: begin
        if (start_i) begin
          ctrl_d    = CAPTURE;
          base_d    = base_adr_i;
          acc_cnt_d = '0;
          ovf_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end
      CAPTURE: begin
        if (st_valid) begin
          if (!fifo_full || fifo_pop) begin
            fifo_push = 1'b1;
            acc_cnt_d = acc_cnt_q + CW'(1);
            if (acc_cnt_d == FFT_CNT) ctrl_d = FLUSH;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (word_done && wr_cnt_d == FFT_CNT && fifo_empty) begin
          ctrl_d = IDLE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ctrl_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any capture immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q        <= IDLE;
      wr_q          <= W_IDLE;
      base_q        <= '0;
      acc_cnt_q     <= '0;
      wr_cnt_q      <= '0;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      m_write_q     <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      wr_q          <= wr_d;
      base_q        <= base_d;
      acc_cnt_q     <= acc_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      ovf_q         <= ovf_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      m_write_q     <= m_write_d;
    end
  end

endmodule

// File: tb/tb_bel_fft_sample_loader.sv
// Bench for the FFT sample loader: a 16-bit and a 32-bit instance share the
// stimulus; a bus monitor records accepted writes for comparison against the
// expected buffer image built from the samples sent.
module tb_bel_fft_sample_loader;

  localparam int unsigned FFT16 = 16;
  localparam int unsigned FFT32 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] st_data = '0;
  logic        st_valid = 1'b0;
  logic [31:0] base_adr = '0;
  logic        start16 = 1'b0, start32 = 1'b0;
  logic        wreq = 1'b0;
  logic        sel32 = 1'b0;

  logic [31:0] a16, d16, a32, d32;
  logic        rdy16, w16, b16, dn16, ov16;
  logic        rdy32, w32, b32, dn32, ov32;

  always #5 clk = ~clk;

  bel_fft_sample_loader #(.word_width(16), .fft_size(FFT16), .fifo_depth(8)) u_d16 (
    .clk_i(clk), .rst_i(rst_n), .st_data(st_data[15:0]), .st_valid(st_valid), .st_ready(rdy16),
    .base_adr_i(base_adr), .start_i(start16), .m_address(a16), .m_writedata(d16), .m_write(w16),
    .m_waitrequest(wreq), .busy_o(b16), .done_o(dn16), .overflow_o(ov16));

  bel_fft_sample_loader #(.word_width(32), .fft_size(FFT32), .fifo_depth(4)) u_d32 (
    .clk_i(clk), .rst_i(rst_n), .st_data(st_data), .st_valid(st_valid), .st_ready(rdy32),
    .base_adr_i(base_adr), .start_i(start32), .m_address(a32), .m_writedata(d32), .m_write(w32),
    .m_waitrequest(wreq), .busy_o(b32), .done_o(dn32), .overflow_o(ov32));

  logic [31:0] mon_a, mon_d;
  logic        mon_w, mon_busy, mon_done, mon_ovf;
  assign mon_a    = sel32 ? a32 : a16;
  assign mon_d    = sel32 ? d32 : d16;
  assign mon_w    = sel32 ? w32 : w16;
  assign mon_busy = sel32 ? b32 : b16;
  assign mon_done = sel32 ? dn32 : dn16;
  assign mon_ovf  = sel32 ? ov32 : ov16;

  // Bus monitor: accepted writes, done pulses, and protocol anomalies.
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int unsigned done_cnt = 0;
  int unsigned mon_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_a = '0, prev_d = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (mon_w !== 1'b1 || mon_a !== prev_a || mon_d !== prev_d)) begin
        mon_err++;
        $display("hold violation at %0t: a=%h d=%h w=%b", $time, mon_a, mon_d, mon_w);
      end
      if (mon_done && mon_busy) mon_err++;
      prev_stall = mon_w && wreq;
      prev_a     = mon_a;
      prev_d     = mon_d;
      if (mon_w && !wreq) begin
        wa_q.push_back(mon_a);
        wd_q.push_back(mon_d);
      end
      if (mon_done) done_cnt++;
    end
  end

  // Slave model: 0 = always ready, 1 = random stalls, 2 = stall one write.
  int          wmode = 0;
  int unsigned stall_idx = 0, stall_len = 0, stall_base = 0;
  int unsigned stall_cnt = 0;

  always @(posedge clk) begin
    #1;
    case (wmode)
      1: wreq = ($urandom_range(0, 3) == 0);
      2: begin
        if (mon_w && wa_q.size() == stall_base + stall_idx && stall_cnt < stall_len) begin
          wreq = 1'b1;
          stall_cnt++;
        end else begin
          wreq = 1'b0;
        end
      end
      default: begin
        wreq      = 1'b0;
        stall_cnt = 0;
      end
    endcase
  end

  int          total = 0;
  int          bad = 0;
  logic [31:0] sent_q[$];
  logic [31:0] preset_q[$];

  // Arms one instance, streams samples, waits for done, then compares the
  // written buffer image with the one implied by the samples sent.
  task automatic capture_and_check(input bit is32, input logic [31:0] base, input int vmode,
                                   input bit drops, input int restart_at, input string tag);
    int unsigned n_ff    = is32 ? FFT32 : FFT16;
    int unsigned n_words = is32 ? 2 * FFT32 : FFT16;
    int unsigned snap_w, snap_done, snap_err, nsent, j;
    bit          got_done, want;
    logic [31:0] smp, exp_a, exp_d;
    sent_q.delete();
    sel32 = is32;
    @(posedge clk); #1;
    snap_w     = wa_q.size();
    snap_done  = done_cnt;
    snap_err   = mon_err;
    stall_base = snap_w;
    base_adr   = base;
    st_valid   = 1'b0;
    if (is32) start32 = 1'b1; else start16 = 1'b1;
    @(negedge clk);
    total++;
    if (mon_busy !== 1'b0) begin bad++; $display("FAIL %s busy_pre: got %b want 0", tag, mon_busy); end
    @(posedge clk); #1;
    start16  = 1'b0;
    start32  = 1'b0;
    base_adr = $urandom;
    @(negedge clk);
    total++;
    if (mon_busy !== 1'b1) begin bad++; $display("FAIL %s busy_rise: got %b want 1", tag, mon_busy); end
    total++;
    if (mon_ovf !== 1'b0) begin bad++; $display("FAIL %s ovf_clear: got %b want 0", tag, mon_ovf); end
    nsent    = 0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      start16 = 1'b0;
      start32 = 1'b0;
      if (cyc == restart_at) begin
        if (is32) start32 = 1'b1; else start16 = 1'b1;
      end
      case (vmode)
        1:       want = (cyc % 2 == 0);
        2:       want = ($urandom_range(0, 2) != 0);
        default: want = 1'b1;
      endcase
      want     = want && (drops || nsent < n_ff);
      st_valid = want;
      if (want) begin
        smp     = (nsent < preset_q.size()) ? preset_q[nsent] : $urandom;
        st_data = smp;
        sent_q.push_back(is32 ? smp : {16'h0000, smp[15:0]});
        nsent++;
      end
      if (done_cnt != snap_done) begin
        got_done = 1'b1;
        break;
      end
    end
    st_valid = 1'b0;
    start16  = 1'b0;
    start32  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (!got_done) begin bad++; $display("FAIL %s done_timeout: got none want 1 pulse", tag); end
    total++;
    if (done_cnt - snap_done != 1) begin
      bad++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt - snap_done);
    end
    total++;
    if (wa_q.size() - snap_w != n_words) begin
      bad++; $display("FAIL %s write_count: got %0d want %0d", tag, wa_q.size() - snap_w, n_words);
    end
    j = 0;
    for (int unsigned k = 0; k < n_words && snap_w + k < wa_q.size(); k++) begin
      if (is32) exp_a = base + 32'(k / 2) * 8 + ((k % 2 == 1) ? 32'd4 : 32'd0);
      else      exp_a = base + 32'(k) * 4;
      total++;
      if (wa_q[snap_w + k] !== exp_a) begin
        bad++; $display("FAIL %s addr[%0d]: got %h want %h", tag, k, wa_q[snap_w + k], exp_a);
      end
      if (drops) begin
        while (j < sent_q.size() && sent_q[j] !== wd_q[snap_w + k]) j++;
        total++;
        if (j >= sent_q.size()) begin
          bad++; $display("FAIL %s order[%0d]: got %h want in-order sent sample", tag, k, wd_q[snap_w + k]);
        end else begin
          j++;
        end
      end else begin
        if (is32 && k % 2 == 1)      exp_d = 32'h0;
        else if ((is32 ? k / 2 : k) < sent_q.size()) exp_d = sent_q[is32 ? k / 2 : k];
        else                          exp_d = 32'hxxxx_xxxx;
        total++;
        if (wd_q[snap_w + k] !== exp_d) begin
          bad++; $display("FAIL %s data[%0d]: got %h want %h", tag, k, wd_q[snap_w + k], exp_d);
        end
      end
    end
    total++;
    if (mon_ovf !== drops) begin bad++; $display("FAIL %s overflow: got %b want %b", tag, mon_ovf, drops); end
    total++;
    if (mon_busy !== 1'b0) begin bad++; $display("FAIL %s busy_end: got %b want 0", tag, mon_busy); end
    total++;
    if (mon_err != snap_err) begin
      bad++; $display("FAIL %s protocol: got %0d anomalies want 0", tag, mon_err - snap_err);
    end
    preset_q.delete();
  endtask

  task automatic test_reset();
    total++;
    if ({rdy16, w16, b16, dn16, ov16} !== 5'b10000) begin
      bad++; $display("FAIL reset16_flags: got %b want 10000", {rdy16, w16, b16, dn16, ov16});
    end
    total++;
    if ({a16, d16} !== 64'h0) begin bad++; $display("FAIL reset16_bus: got %h want 0", {a16, d16}); end
    total++;
    if ({rdy32, w32, b32, dn32, ov32} !== 5'b10000) begin
      bad++; $display("FAIL reset32_flags: got %b want 10000", {rdy32, w32, b32, dn32, ov32});
    end
    total++;
    if ({a32, d32} !== 64'h0) begin bad++; $display("FAIL reset32_bus: got %h want 0", {a32, d32}); end
  endtask

  task automatic test_idle_discard();
    int unsigned snap = wa_q.size();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      st_valid = 1'b1;
      st_data  = $urandom;
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (wa_q.size() != snap) begin bad++; $display("FAIL idle_writes: got %0d want 0", wa_q.size() - snap); end
    total++;
    if ({b16, b32, w16, w32} !== 4'b0000) begin
      bad++; $display("FAIL idle_busy: got %b want 0000", {b16, b32, w16, w32});
    end
  endtask

  task automatic test_basic16();
    wmode = 0;
    preset_q = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_FFFF};
    capture_and_check(1'b0, 32'h0000_1000, 0, 1'b0, -1, "basic16");
  endtask

  task automatic test_pack32();
    wmode = 0;
    preset_q = '{32'h1234_5678};
    capture_and_check(1'b1, 32'h0000_2000, 0, 1'b0, -1, "pack32");
    wmode = 1;
    capture_and_check(1'b1, 32'h0000_3004, 2, 1'b0, -1, "pack32_rand");
    wmode = 0;
  endtask

  task automatic test_backpressure();
    stall_idx = 1;
    stall_len = 5;
    wmode     = 2;
    capture_and_check(1'b0, 32'h0000_4000, 1, 1'b0, -1, "backpressure");
    wmode = 0;
  endtask

  task automatic test_ignored_start();
    wmode = 0;
    capture_and_check(1'b0, 32'h0000_5000, 2, 1'b0, 5, "ignored_start");
  endtask

  task automatic test_overflow();
    stall_idx = 0;
    stall_len = 20;
    wmode     = 2;
    capture_and_check(1'b0, 32'h0000_6000, 0, 1'b1, -1, "overflow");
    wmode = 0;
  endtask

  task automatic test_back_to_back();
    wmode = 1;
    capture_and_check(1'b0, 32'hFFFF_FFF0, 0, 1'b0, -1, "b2b_wrap");
    wmode = 0;
    capture_and_check(1'b0, 32'h0000_8000, 0, 1'b0, -1, "b2b_full_rate");
  endtask

  task automatic test_reset_mid();
    int unsigned snap, snap_done;
    bit          reached = 1'b0;
    wmode = 0;
    sel32 = 1'b0;
    @(posedge clk); #1;
    snap      = wa_q.size();
    snap_done = done_cnt;
    base_adr  = 32'h0000_7000;
    start16   = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      st_valid = 1'b1;
      st_data  = $urandom;
      if (wa_q.size() - snap >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    total++;
    if (!reached) begin bad++; $display("FAIL rstmid_progress: got %0d writes want 2", wa_q.size() - snap); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rdy16, w16, b16, dn16, ov16} !== 5'b10000) begin
      bad++; $display("FAIL rstmid_flags: got %b want 10000", {rdy16, w16, b16, dn16, ov16});
    end
    total++;
    if ({a16, d16} !== 64'h0) begin bad++; $display("FAIL rstmid_bus: got %h want 0", {a16, d16}); end
    st_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt != snap_done) begin
      bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - snap_done);
    end
    capture_and_check(1'b0, 32'h0000_7000, 2, 1'b0, -1, "after_reset");
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_idle_discard();
    test_basic16();
    test_pack32();
    test_backpressure();
    test_ignored_start();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
